regfile_wb_queue: RTL and testbench

//  Write-side initiator for the 32x32 register file: buffers writeback requests from the

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wb_match.sv | 36 +++
 rtl/regfile_wb_queue.sv | 113 +++++++++++
 tb/tb_regfile_wb_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_match.sv
// Per-read-port hazard detection over the age-ordered writeback queue.
// With WB_FWD_EN defined, also returns data of the youngest matching entry.
module regfile_wb_match
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic [ADDR_W-1:0]     chk_addr,
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      valid,
    output logic                  hazard,
    output logic [DATA_W-1:0]     fwd_data
);
    logic              hit_s;
    logic [DATA_W-1:0] sel_s;

    // Entries are oldest-first, so the last hit in the scan is the youngest.
    always_comb begin
        hazard = 1'b0;
        sel_s  = {DATA_W{1'b0}};
        hit_s  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s  = valid[i] && (entries[i].addr == chk_addr) && (chk_addr != REG_ZERO);
            hazard = hazard | hit_s;
            sel_s  = hit_s ? entries[i].data : sel_s;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_data = sel_s;
`else
    assign fwd_data = {DATA_W{1'b0}};
`endif
endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback FIFO driving the register file write port, with RAW hazard
// reporting on two read addresses. Optional forwarding under WB_FWD_EN.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         In_Valid,
    output logic                         In_Ready,
    input  logic [ADDR_W-1:0]            In_Addr,
    input  logic [DATA_W-1:0]            In_Data,
    input  logic                         Hold,
    input  logic                         Flush,
    output logic                         Write_Reg,
    output logic [ADDR_W-1:0]            W_Addr,
    output logic [DATA_W-1:0]            W_Data,
    input  logic [ADDR_W-1:0]            Chk_Addr_A,
    input  logic [ADDR_W-1:0]            Chk_Addr_B,
    output logic                         Hazard_A,
    output logic                         Hazard_B,
    output logic [DATA_W-1:0]            Fwd_Data_A,
    output logic [DATA_W-1:0]            Fwd_Data_B,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t [DEPTH-1:0] mem_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  empty_s;
    logic                  accept_s;
    logic                  store_s;
    logic                  pop_s;
    wb_entry_t [DEPTH-1:0] ord_s;
    logic [DEPTH-1:0]      vld_s;
    logic [PTR_W-1:0]      idx_s;

    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign In_Ready  = (count_r < CNT_W'(DEPTH)) && !Flush;
    assign accept_s  = In_Valid && In_Ready;
    // r0 writes complete the handshake but never occupy a slot.
    assign store_s   = accept_s && (In_Addr != REG_ZERO);
    assign Write_Reg = !empty_s && !Hold;
    assign pop_s     = Write_Reg && !Flush;
    assign W_Addr    = empty_s ? {ADDR_W{1'b0}} : mem_r[rd_ptr_r].addr;
    assign W_Data    = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r].data;
    assign Count     = count_r;

    // Queue pointers, occupancy and storage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (Flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (store_s) begin
                mem_r[wr_ptr_r].addr <= In_Addr;
                mem_r[wr_ptr_r].data <= In_Data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({store_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Present entries oldest-first so the matchers can resolve youngest priority.
    always_comb begin
        ord_s = '0;
        vld_s = {DEPTH{1'b0}};
        idx_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_s    = rd_ptr_r + PTR_W'(i);
            ord_s[i] = mem_r[idx_s];
            vld_s[i] = (CNT_W'(i) < count_r);
        end
    end

    regfile_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_a (
        .chk_addr (Chk_Addr_A),
        .entries  (ord_s),
        .valid    (vld_s),
        .hazard   (Hazard_A),
        .fwd_data (Fwd_Data_A)
    );

    regfile_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_b (
        .chk_addr (Chk_Addr_B),
        .entries  (ord_s),
        .valid    (vld_s),
        .hazard   (Hazard_B),
        .fwd_data (Fwd_Data_B)
    );
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue; honours WB_FWD_EN for forward data.
module tb_regfile_wb_queue;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        In_Valid;
    logic        In_Ready;
    logic [4:0]  In_Addr;
    logic [31:0] In_Data;
    logic        Hold;
    logic        Flush;
    logic        Write_Reg;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic [4:0]  Chk_Addr_A;
    logic [4:0]  Chk_Addr_B;
    logic        Hazard_A;
    logic        Hazard_B;
    logic [31:0] Fwd_Data_A;
    logic [31:0] Fwd_Data_B;
    logic [2:0]  Count;

    int errors = 0;
    int checks = 0;
    logic [31:0] fwd_a_exp;
    logic [31:0] fwd_b_exp;

    regfile_wb_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .In_Addr    (In_Addr),
        .In_Data    (In_Data),
        .Hold       (Hold),
        .Flush      (Flush),
        .Write_Reg  (Write_Reg),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .Chk_Addr_A (Chk_Addr_A),
        .Chk_Addr_B (Chk_Addr_B),
        .Hazard_A   (Hazard_A),
        .Hazard_B   (Hazard_B),
        .Fwd_Data_A (Fwd_Data_A),
        .Fwd_Data_B (Fwd_Data_B),
        .Count      (Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0; In_Valid = 1'b0; In_Addr = 5'd0; In_Data = 32'd0;
        Hold = 1'b0; Flush = 1'b0; Chk_Addr_A = 5'd0; Chk_Addr_B = 5'd0;
        #12;
        chk("rst_count", {29'd0, Count}, 32'd0);
        chk("rst_wreg", {31'd0, Write_Reg}, 32'd0);
        chk("rst_waddr", {27'd0, W_Addr}, 32'd0);
        chk("rst_wdata", W_Data, 32'd0);
        chk("rst_haz_a", {31'd0, Hazard_A}, 32'd0);
        chk("rst_fwd_a", Fwd_Data_A, 32'd0);
        tick();
        Reset_n = 1'b1;
        #1;
        chk("rst_ready", {31'd0, In_Ready}, 32'd1);

        // Single write, one-cycle latency
        In_Valid = 1'b1; In_Addr = 5'd5; In_Data = 32'hDEADBEEF;
        tick();
        In_Valid = 1'b0;
        #1;
        chk("t2_wreg", {31'd0, Write_Reg}, 32'd1);
        chk("t2_waddr", {27'd0, W_Addr}, 32'd5);
        chk("t2_wdata", W_Data, 32'hDEADBEEF);
        chk("t2_count1", {29'd0, Count}, 32'd1);
        tick();
        chk("t2_wreg_off", {31'd0, Write_Reg}, 32'd0);
        chk("t2_count0", {29'd0, Count}, 32'd0);

        // Reset in the middle of a drain
        Hold = 1'b1; In_Valid = 1'b1; In_Addr = 5'd3; In_Data = 32'h3;
        tick();
        In_Addr = 5'd4; In_Data = 32'h4;
        tick();
        In_Valid = 1'b0; Hold = 1'b0;
        #1;
        chk("t1_count2", {29'd0, Count}, 32'd2);
        chk("t1_wreg_pre", {31'd0, Write_Reg}, 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("t1_wreg_rst", {31'd0, Write_Reg}, 32'd0);
        chk("t1_count_rst", {29'd0, Count}, 32'd0);
        tick();
        Reset_n = 1'b1;
        #1;
        chk("t1_ready", {31'd0, In_Ready}, 32'd1);
        chk("t1_wreg_after", {31'd0, Write_Reg}, 32'd0);

        // Fill under Hold, stall a fifth request, then drain in order
        Hold = 1'b1; In_Valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            In_Addr = 5'(i); In_Data = 32'h100 + 32'(i);
            tick();
        end
        In_Addr = 5'd9; In_Data = 32'h109;
        #1;
        chk("t3_count4", {29'd0, Count}, 32'd4);
        chk("t3_ready0", {31'd0, In_Ready}, 32'd0);
        tick();
        chk("t3_stall_count", {29'd0, Count}, 32'd4);
        Hold = 1'b0;
        #1;
        chk("t3_w1_addr", {27'd0, W_Addr}, 32'd1);
        chk("t3_w1_en", {31'd0, Write_Reg}, 32'd1);
        chk("t3_w1_ready", {31'd0, In_Ready}, 32'd0);
        tick();
        chk("t3_w2_addr", {27'd0, W_Addr}, 32'd2);
        chk("t3_w2_en", {31'd0, Write_Reg}, 32'd1);
        chk("t3_w2_ready", {31'd0, In_Ready}, 32'd1);
        chk("t3_w2_count", {29'd0, Count}, 32'd3);
        tick();
        In_Valid = 1'b0;
        #1;
        chk("t3_w3_addr", {27'd0, W_Addr}, 32'd3);
        chk("t3_w3_data", W_Data, 32'h103);
        chk("t3_w3_count", {29'd0, Count}, 32'd3);
        tick();
        chk("t3_w4_addr", {27'd0, W_Addr}, 32'd4);
        chk("t3_w4_en", {31'd0, Write_Reg}, 32'd1);
        tick();
        chk("t3_w9_addr", {27'd0, W_Addr}, 32'd9);
        chk("t3_w9_data", W_Data, 32'h109);
        chk("t3_w9_count", {29'd0, Count}, 32'd1);
        tick();
        chk("t3_empty", {29'd0, Count}, 32'd0);
        chk("t3_wreg_off", {31'd0, Write_Reg}, 32'd0);

        // r0 writes are accepted and dropped
        In_Valid = 1'b1; In_Addr = 5'd0; In_Data = 32'h1234;
        #1;
        chk("t4_ready", {31'd0, In_Ready}, 32'd1);
        tick();
        In_Valid = 1'b0;
        #1;
        chk("t4_count", {29'd0, Count}, 32'd0);
        chk("t4_wreg", {31'd0, Write_Reg}, 32'd0);
        tick();
        chk("t4_wreg2", {31'd0, Write_Reg}, 32'd0);

        // Hazard detection and youngest-entry forwarding
        Hold = 1'b1; In_Valid = 1'b1; In_Addr = 5'd7; In_Data = 32'h11;
        tick();
        In_Data = 32'h22;
        tick();
        In_Valid = 1'b0; Chk_Addr_A = 5'd7; Chk_Addr_B = 5'd0;
        #1;
`ifdef WB_FWD_EN
        fwd_a_exp = 32'h22;
        fwd_b_exp = 32'h33;
`else
        fwd_a_exp = 32'h0;
        fwd_b_exp = 32'h0;
`endif
        chk("t5_haz_a", {31'd0, Hazard_A}, 32'd1);
        chk("t5_haz_b_r0", {31'd0, Hazard_B}, 32'd0);
        chk("t5_fwd_a", Fwd_Data_A, fwd_a_exp);
        chk("t5_fwd_b_r0", Fwd_Data_B, 32'd0);
        chk("t5_head", W_Data, 32'h11);
        chk("t5_hold_wreg", {31'd0, Write_Reg}, 32'd0);
        In_Valid = 1'b1; In_Addr = 5'd3; In_Data = 32'h33; Chk_Addr_B = 5'd3;
        #1;
        chk("t5_haz_b_inflight", {31'd0, Hazard_B}, 32'd0);
        tick();
        In_Valid = 1'b0;
        #1;
        chk("t5_haz_b_queued", {31'd0, Hazard_B}, 32'd1);
        chk("t5_fwd_b", Fwd_Data_B, fwd_b_exp);
        chk("t5_count3", {29'd0, Count}, 32'd3);

        // Flush overrides a simultaneous push
        Flush = 1'b1; In_Valid = 1'b1; In_Addr = 5'd12; In_Data = 32'h44;
        #1;
        chk("t6_ready0", {31'd0, In_Ready}, 32'd0);
        tick();
        Flush = 1'b0; In_Valid = 1'b0; Hold = 1'b0;
        #1;
        chk("t6_count0", {29'd0, Count}, 32'd0);
        chk("t6_wreg", {31'd0, Write_Reg}, 32'd0);
        chk("t6_waddr", {27'd0, W_Addr}, 32'd0);
        chk("t6_haz_a", {31'd0, Hazard_A}, 32'd0);
        chk("t6_haz_b", {31'd0, Hazard_B}, 32'd0);
        tick();
        chk("t6_wreg2", {31'd0, Write_Reg}, 32'd0);
        chk("t6_count_hold", {29'd0, Count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
